// File: rtl/d_flip_flop_en.sv
// Rising-edge D register with synchronous active-high reset and clock enable.
// Chains into shift registers and doubles as a WIDTH-bit enabled register.
module d_flip_flop_en #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  // Declaration init gives the power-up value, both in simulation and as the FPGA register init.
  logic [WIDTH-1:0] q_q = RESET_VALUE;

  // Reset outranks enable. X on d passes through when capturing.
  always_comb begin
    q_d = q_q;
    if (rst) begin
      q_d = RESET_VALUE;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: tb/tb_d_flip_flop_en.sv
// Bench for d_flip_flop_en: directed cases plus randomized traffic against a behavioural model,
// covering a 1-bit cell, an 8-bit cell with a non-zero reset value and a 4-stage chain.
module tb_d_flip_flop_en;

  logic       clk = 1'b0;
  logic       rst1 = 1'b0, en1 = 1'b0, d1 = 1'b0;
  logic       q1;
  logic       rst8 = 1'b0, en8 = 1'b0;
  logic [7:0] d8 = 8'h00;
  logic [7:0] q8;
  logic       rstc = 1'b0, enc = 1'b0, s_in = 1'b0;
  wire  [3:0] ch_q;
  wire  [3:0] ch_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  d_flip_flop_en u_dut1 (
    .clk (clk),
    .rst (rst1),
    .en  (en1),
    .d   (d1),
    .q   (q1)
  );

  d_flip_flop_en #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) u_dut8 (
    .clk (clk),
    .rst (rst8),
    .en  (en8),
    .d   (d8),
    .q   (q8)
  );

  // Stage n+1 takes stage n's q; serial input enters stage 0.
  assign ch_d = {ch_q[2:0], s_in};

  d_flip_flop_en u_ch0 (.clk(clk), .rst(rstc), .en(enc), .d(ch_d[0]), .q(ch_q[0]));
  d_flip_flop_en u_ch1 (.clk(clk), .rst(rstc), .en(enc), .d(ch_d[1]), .q(ch_q[1]));
  d_flip_flop_en u_ch2 (.clk(clk), .rst(rstc), .en(enc), .d(ch_d[2]), .q(ch_q[2]));
  d_flip_flop_en u_ch3 (.clk(clk), .rst(rstc), .en(enc), .d(ch_d[3]), .q(ch_q[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp8;
  logic [3:0] exp_ch;
  logic [3:0] serial;

  initial begin
    // Power-up, before any edge
    #1;
    check("pwrup_q1", 32'(q1), 32'h0);
    check("pwrup_q8", 32'(q8), 32'hA5);
    check("pwrup_chain", 32'(ch_q), 32'h0);

    // Reset beats enable
    en1 = 1'b1; d1 = 1'b1;
    tick();
    check("load_one", 32'(q1), 32'h1);
    rst1 = 1'b1;
    tick();
    check("rst_clears", 32'(q1), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold", 32'(q1), 32'h0);
    end

    // Capture then hold
    rst1 = 1'b0; en1 = 1'b1; d1 = 1'b1;
    tick();
    check("capture_1", 32'(q1), 32'h1);
    en1 = 1'b0; d1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_1", 32'(q1), 32'h1);
    end
    en1 = 1'b1;
    tick();
    check("capture_0", 32'(q1), 32'h0);

    // Glitches between edges must not reach q
    d1 = 1'b1; #2; d1 = 1'b0; #1;
    check("glitch_mid", 32'(q1), 32'h0);
    tick();
    check("glitch_edge", 32'(q1), 32'h0);
    d1 = 1'b1;
    tick();
    check("capture_1b", 32'(q1), 32'h1);
    en1 = 1'b0;
    #2; rst1 = 1'b1; #2; rst1 = 1'b0; #1;
    check("rst_pulse_mid", 32'(q1), 32'h1);
    tick();
    check("rst_pulse_edge", 32'(q1), 32'h1);

    // Chain: serial 1,0,1,1 then 0,0
    rstc = 1'b1;
    tick();
    check("chain_rst", 32'(ch_q), 32'h0);
    rstc = 1'b0; enc = 1'b1;
    serial = 4'b1011;
    exp_ch = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      s_in = serial[i];
      exp_ch = {exp_ch[2:0], s_in};
      tick();
      check("chain_shift", 32'(ch_q), 32'(exp_ch));
    end
    check("chain_1011", 32'(ch_q), 32'hB);
    s_in = 1'b0;
    tick();
    tick();
    check("chain_1100", 32'(ch_q), 32'hC);
    exp_ch = 4'b1100;

    // Chain randomized against a history model
    for (int i = 0; i < 60; i++) begin
      s_in = 1'($urandom);
      enc  = ($urandom_range(0, 3) != 0);
      rstc = ($urandom_range(0, 15) == 0);
      if (rstc) exp_ch = 4'b0000;
      else if (enc) exp_ch = {exp_ch[2:0], s_in};
      tick();
      check("chain_rand", 32'(ch_q), 32'(exp_ch));
    end

    // 8-bit with non-zero reset value
    rst8 = 1'b1;
    tick();
    check("w8_rst", 32'(q8), 32'hA5);
    rst8 = 1'b0; en8 = 1'b1; d8 = 8'h3C;
    tick();
    check("w8_cap", 32'(q8), 32'h3C);
    rst8 = 1'b1; en8 = 1'b1; d8 = 8'hFF;
    tick();
    check("w8_rst_en", 32'(q8), 32'hA5);

    exp8 = 8'hA5;
    for (int i = 0; i < 200; i++) begin
      d8   = 8'($urandom);
      en8  = 1'($urandom);
      rst8 = ($urandom_range(0, 9) == 0);
      if (rst8) exp8 = 8'hA5;
      else if (en8) exp8 = d8;
      tick();
      check("w8_rand", 32'(q8), 32'(exp8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
